// File: rtl/instr_mem_fetch.sv
// Instruction memory with a registered fetch port and a runtime program-load port.
// After reset, a sweep fills the memory with NOP, and then the block enters RUN.
module instr_mem_fetch #(
  parameter int              XLEN  = 32,
  parameter int              DEPTH = 32,
  parameter int              PC_W  = 32,
  parameter logic [XLEN-1:0] NOP   = XLEN'(32'h00000013),
  localparam int             AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic            fetch_req,
  input  logic [PC_W-1:0] pc,
  input  logic            fetch_stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instruction,
  output logic [PC_W-1:0] instr_pc,
  output logic            fetch_err,
  input  logic            prog_we,
  input  logic [AW-1:0]   prog_addr,
  input  logic [XLEN-1:0] prog_data,
  output logic            prog_ack
);

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     init_cnt_q, init_cnt_d;
  logic              ready_q, valid_q, valid_d, err_q, err_d, ack_q;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]   ipc_q, ipc_d;
  logic [XLEN-1:0]   mem_q [DEPTH];

  logic              misaligned, out_of_range;
  logic [AW-1:0]     word_idx;

  assign misaligned   = |pc[1:0];
  assign out_of_range = {2'b00, pc[PC_W-1:2]} >= PC_W'(DEPTH);
  assign word_idx     = pc[AW+1:2];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    err_d      = err_q;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (!fetch_stall) begin
          if (fetch_req) begin
            valid_d = 1'b1;
            ipc_d   = pc;
            if (misaligned || out_of_range) begin
              instr_d = NOP;
              err_d   = 1'b1;
            end else begin
              instr_d = mem_q[word_idx];
              err_d   = 1'b0;
            end
          end else begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            instr_d = NOP;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      ipc_q      <= '0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= (state_d == RUN);
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      err_q      <= err_d;
      ack_q      <= (state_q == RUN) && prog_we;
    end
  end

  // The fetch above reads mem_q before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) mem_q[init_cnt_q] <= NOP;
      else if (prog_we)    mem_q[prog_addr]  <= prog_data;
    end
  end

  assign ready       = ready_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;
  assign fetch_err   = err_q;
  assign prog_ack    = ack_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: directed scenarios plus random traffic
// compared against a cycle-level behavioural model.
module tb_instr_mem_fetch;

  localparam int          DEPTH = 32;
  localparam logic [31:0] NOPI  = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, ready, fetch_req, fetch_stall, instr_valid, fetch_err, prog_we, prog_ack;
  logic [31:0] pc, instruction, instr_pc, prog_data;
  logic [4:0]  prog_addr;

  int compared   = 0;
  int mismatched = 0;

  instr_mem_fetch #(.XLEN(32), .DEPTH(DEPTH), .PC_W(32), .NOP(NOPI)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .fetch_req(fetch_req), .pc(pc), .fetch_stall(fetch_stall),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .fetch_err(fetch_err), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_ack(prog_ack)
  );

  always #5 clk = ~clk;

  // Reference model: memory is all NOP once reset is seen, RUN begins DEPTH cycles after release.
  logic        mReady, mValid, mErr, mAck, modelOk = 1'b0;
  logic [31:0] mInstr, mPc;
  logic [31:0] mMem [DEPTH];
  int          sinceRel;

  always @(posedge clk) begin
    if (reset) begin
      mReady = 0; mValid = 0; mInstr = NOPI; mPc = 0; mErr = 0; mAck = 0;
      sinceRel = 0;
      for (int i = 0; i < DEPTH; i++) mMem[i] = NOPI;
      modelOk = 1'b1;
    end else if (modelOk) begin
      if (sinceRel >= DEPTH) begin
        mAck = prog_we;
        if (!fetch_stall) begin
          if (fetch_req) begin
            mValid = 1; mPc = pc;
            if ((pc % 4) != 0 || (pc >> 2) >= 32'(DEPTH)) begin
              mInstr = NOPI; mErr = 1;
            end else begin
              mInstr = mMem[int'(pc >> 2)]; mErr = 0;
            end
          end else begin
            mValid = 0; mErr = 0; mInstr = NOPI;
          end
        end
        if (prog_we) mMem[prog_addr] = prog_data;
      end else begin
        mAck = 0;
      end
      if (sinceRel < 1000) sinceRel++;
      mReady = (sinceRel >= DEPTH);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (modelOk) begin
      checkOutput("ready",       64'(ready),       64'(mReady));
      checkOutput("instr_valid", 64'(instr_valid), 64'(mValid));
      checkOutput("instruction", 64'(instruction), 64'(mInstr));
      checkOutput("instr_pc",    64'(instr_pc),    64'(mPc));
      checkOutput("fetch_err",   64'(fetch_err),   64'(mErr));
      checkOutput("prog_ack",    64'(prog_ack),    64'(prog_ack === 1'bx ? 1'b0 : mAck));
    end
  end

  // Drives one cycle of inputs and returns just after the edge that consumed them.
  task automatic applyStimulus(input logic rst, input logic req, input logic [31:0] pcv,
                               input logic stall, input logic we, input logic [4:0] addr,
                               input logic [31:0] data);
    @(negedge clk);
    reset = rst; fetch_req = req; pc = pcv; fetch_stall = stall;
    prog_we = we; prog_addr = addr; prog_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rst);
    applyStimulus(rst, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] pcv);
    applyStimulus(1'b0, 1'b1, pcv, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic waitReady(input string name);
    int lowCnt = 0;
    while (!ready && lowCnt < 200) begin
      lowCnt++;
      idle(1'b0);
    end
    checkOutput(name, 64'(lowCnt), 64'd32);
  endtask

  task automatic checkFetch(input string name, input logic [31:0] inst, input logic [31:0] ipc,
                            input logic err);
    checkOutput({name, "_valid"}, 64'(instr_valid), 64'd1);
    checkOutput({name, "_instr"}, 64'(instruction), 64'(inst));
    checkOutput({name, "_pc"},    64'(instr_pc),    64'(ipc));
    checkOutput({name, "_err"},   64'(fetch_err),   64'(err));
  endtask

  initial begin
    reset = 1; fetch_req = 0; pc = 0; fetch_stall = 0; prog_we = 0; prog_addr = 0; prog_data = 0;

    idle(1'b1);
    idle(1'b1);
    checkOutput("rst_ready", 64'(ready), 64'd0);
    checkOutput("rst_instr", 64'(instruction), 64'(NOPI));
    checkOutput("rst_valid", 64'(instr_valid), 64'd0);
    waitReady("init_len");

    fetch(32'd0);
    checkFetch("pc0", NOPI, 32'd0, 1'b0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd1, 32'h00500313);
    checkOutput("ack_pulse", 64'(prog_ack), 64'd1);
    fetch(32'd4);
    checkOutput("ack_drop", 64'(prog_ack), 64'd0);
    checkFetch("pc4", 32'h00500313, 32'd4, 1'b0);

    fetch(32'd6);
    checkFetch("pc6", NOPI, 32'd6, 1'b1);
    fetch(32'd128);
    checkFetch("pc128", NOPI, 32'd128, 1'b1);
    fetch(32'd124);
    checkFetch("pc124", NOPI, 32'd124, 1'b0);

    fetch(32'd4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 5'd0, 32'h0);
      checkFetch("stall", 32'h00500313, 32'd4, 1'b0);
    end
    fetch(32'd0);
    checkFetch("unstall", NOPI, 32'd0, 1'b0);

    applyStimulus(1'b0, 1'b1, 32'd8, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF);
    checkFetch("rbw_old", NOPI, 32'd8, 1'b0);
    fetch(32'd8);
    checkFetch("rbw_new", 32'hDEADBEEF, 32'd8, 1'b0);

    idle(1'b1);
    for (int i = 0; i < 10; i++) idle(1'b0);
    idle(1'b1);
    waitReady("reinit_len");

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'd1, 32'h12345678);
    applyStimulus(1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 5'd3, 32'hCAFEF00D);
    checkOutput("rstw_ack", 64'(prog_ack), 64'd0);
    checkOutput("rstw_ready", 64'(ready), 64'd0);
    checkOutput("rstw_valid", 64'(instr_valid), 64'd0);
    waitReady("rstw_init_len");
    fetch(32'd4);
    checkFetch("cleared1", NOPI, 32'd4, 1'b0);
    fetch(32'd8);
    checkFetch("cleared2", NOPI, 32'd8, 1'b0);
    fetch(32'd12);
    checkFetch("cleared3", NOPI, 32'd12, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      case ($urandom_range(0, 3))
        0, 1:    rpc = 32'($urandom_range(0, DEPTH - 1)) << 2;
        2:       rpc = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
        default: rpc = $urandom;
      endcase
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rpc,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                    5'($urandom_range(0, DEPTH - 1)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_mem_fetch.md
Name: instr_mem_fetch

Overview:
- Parametrised, synchronous-read instruction memory for the single-cycle/pipelined RISC-V datapath.
- Byte-addressed PC input and registered fetch output with valid and stall.
- Detects misaligned and out-of-range fetches.
- Runtime program-load write port replaces hard-coded contents; a post-reset init sweep fills memory with NOPs.

Parameters:
XLEN, 32, instruction width in bits
DEPTH, 32, number of instruction words (power of two, >=2)
PC_W, 32, width of byte-addressed PC
NOP, 32'h00000013, fill/error instruction (addi x0,x0,0)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
ready  out  1  high when the block is in RUN and accepts fetch/program traffic
fetch_req  in  1  request a fetch of pc this cycle
pc  in  PC_W  byte address of instruction
fetch_stall  in  1  hold current fetch output
instr_valid  out  1  instruction/instr_pc/fetch_err are meaningful
instruction  out  XLEN  fetched word
instr_pc  out  PC_W  pc that produced instruction
fetch_err  out  1  fetched pc was misaligned or out of range
prog_we  in  1  program-load write strobe
prog_addr  in  clog2(DEPTH)  word index to write
prog_data  in  XLEN  word to write
prog_ack  out  1  one-cycle pulse, write committed

Behaviour:
- Reset values: ready=0, instr_valid=0, instruction=NOP, instr_pc=0, fetch_err=0, prog_ack=0, state=INIT, init_cnt=0.
- FSM states are INIT and RUN.
  - INIT: each cycle writes NOP to mem[init_cnt] and increments init_cnt.
  - At init_cnt==DEPTH-1, the write occurs and the next state is RUN. INIT lasts exactly DEPTH cycles after reset deasserts.
  - ready is registered: it rises on the first RUN cycle.
  - fetch_req and prog_we are ignored in INIT: no ack, no valid.
- RUN, fetch path (one-cycle latency), priority order:
  1. fetch_stall=1: all fetch outputs hold their values, including instr_valid. fetch_req is ignored.
  2. Else fetch_req=1: the next edge sets instr_valid=1 and instr_pc=pc.
     - If pc[1:0]!=0 or pc[PC_W-1:2]>=DEPTH: instruction=NOP, fetch_err=1.
     - Otherwise: instruction=mem[pc[clog2(DEPTH)+1:2]], fetch_err=0.
  3. Else: the next edge sets instr_valid=0, fetch_err=0, instruction=NOP, instr_pc holds.
- RUN, program path:
  - prog_we=1 writes mem[prog_addr]=prog_data at the edge.
  - prog_ack=1 in the following cycle only.
  - Back-to-back writes are allowed, one per cycle, and each is acked.
- Same-cycle write and fetch to the same word: read-before-write. The fetch returns the old word; the next fetch returns the new one.
- prog_we during a stall is still committed. Stall affects the fetch path only.
- reset asserted at any point (mid-INIT, mid-stall, during a write):
  - Next edge returns every output to its reset value.
  - A write presented in that reset cycle is dropped, with no ack.
  - INIT restarts from 0 and memory is refilled with NOP.
- Address arithmetic:
  - Word index is pc>>2, unsigned.
  - No wrap-around: index>=DEPTH is an error, never aliased.

Test Plan:
- Reset 2 cycles then release (DEPTH=32) -> ready=0 for exactly 32 cycles, then 1; fetch pc=0 -> next cycle instr_valid=1, instruction=32'h00000013, fetch_err=0.
- After ready: prog_we addr=1 data=32'h00500313 -> prog_ack pulses 1 cycle later; fetch pc=4 -> instruction=32'h00500313, instr_pc=4.
- Fetch pc=6 -> fetch_err=1, instruction=NOP, instr_valid=1; fetch pc=128 (DEPTH=32) -> fetch_err=1, NOP.
- Fetch pc=4, then assert fetch_stall 3 cycles with pc changed to 0 -> outputs hold 32'h00500313/instr_pc=4 all 3 cycles; release -> pc=0 result next cycle.
- Same cycle prog_we addr=2 data=32'hDEADBEEF and fetch pc=8 -> instruction=NOP (old); refetch pc=8 -> 32'hDEADBEEF.
- Assert reset at INIT cycle 10 and again mid-write (prog_we=1) in RUN -> outputs reset, no prog_ack, full 32-cycle INIT repeats, earlier programmed words read back as NOP.
